// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe
// Two-stage valid/ready SEC-DED decoder for a DATA_W-bit word protected by
// extended Hamming check bits (P Hamming bits + 1 overall-parity bit).
//   Stage 1: recompute check bits, form syndrome s and overall parity pe.
//   Stage 2: classify (clean / correctable / uncorrectable) and optionally
//            flip the addressed data bit.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready is combinational from out_ready
//   in_data/in_chk  received word and CHK_W = P+1 check bits
//   correct_en      per-beat: 1 = apply correction, 0 = pass raw data
//   out_valid/ready output handshake
//   out_data        corrected (or raw) data
//   out_ce/out_ue   correctable / uncorrectable error flags (mutually exclusive)
//   out_syndrome    P-bit Hamming syndrome
//   ce_cnt/ue_cnt   saturating error-event counters, bumped on output handshake
//   cnt_clr         synchronous clear of both counters
module ecc_secded_pipe #(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  // Smallest p with 2^p >= DATA_W+p+1; DATA_W in 4..64 keeps p in 3..7.
  localparam int P      = ((1 << 3) >= DATA_W + 4) ? 3 :
                          ((1 << 4) >= DATA_W + 5) ? 4 :
                          ((1 << 5) >= DATA_W + 6) ? 5 :
                          ((1 << 6) >= DATA_W + 7) ? 6 : 7,
  localparam int CHK_W  = P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ce,
  output logic              out_ue,
  output logic [P-1:0]      out_syndrome,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
  input  logic              cnt_clr
);

  // Highest codeword position; any syndrome above it cannot be a single error.
  localparam int            NPOS   = DATA_W + P;
  localparam logic [P-1:0]  NPOS_L = NPOS[P-1:0];

  // Codeword position of data bit k: the (k+1)-th non-power-of-two position.
  // Walking the powers of two upward and bumping past each one we reach
  // yields 3,5,6,7,9,... for k = 0,1,2,3,4,...
  function automatic int pos_of(input int k);
    int pos;
    pos = k + 1;
    for (int i = 0; i < 8; i++)
      if ((1 << i) <= pos) pos = pos + 1;
    return pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic [2:1] r_vld_pipe;
  logic       w_s1_en;
  logic       w_s2_en;

  // A stage may load when it is empty or its contents move on this cycle;
  // chaining through out_ready avoids a bubble when the pipe is full.
  assign w_s2_en  = !r_vld_pipe[2] || out_ready;
  assign w_s1_en  = !r_vld_pipe[1] || w_s2_en;
  assign in_ready = w_s1_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_s1_en) r_vld_pipe[1] <= in_valid;
      if (w_s2_en) r_vld_pipe[2] <= r_vld_pipe[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: syndrome and overall parity
  // ---------------------------------------------------------------------------
  logic [P-1:0] w_recomp;
  logic [P-1:0] w_syn;
  logic         w_pe;

  always_comb begin
    w_recomp = '0;
    for (int k = 0; k < DATA_W; k++)
      for (int i = 0; i < P; i++)
        if (((pos_of(k) >> i) & 1) == 1)
          w_recomp[i] = w_recomp[i] ^ in_data[k];
  end

  assign w_syn = in_chk[P-1:0] ^ w_recomp;
  // Parity over the whole received codeword: odd means an odd number of flips.
  assign w_pe  = (^in_data) ^ (^in_chk);

  logic [DATA_W-1:0] r_s1_data;
  logic [P-1:0]      r_s1_syn;
  logic              r_s1_pe;
  logic              r_s1_cen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data <= '0;
      r_s1_syn  <= '0;
      r_s1_pe   <= 1'b0;
      r_s1_cen  <= 1'b0;
    end else if (w_s1_en && in_valid) begin
      r_s1_data <= in_data;
      r_s1_syn  <= w_syn;
      r_s1_pe   <= w_pe;
      r_s1_cen  <= correct_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: classify and correct
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_hit;    // one-hot: syndrome addresses data bit k
  logic [DATA_W-1:0] w_flip;
  logic [DATA_W-1:0] w_cdata;
  logic              w_ce;
  logic              w_ue;

  for (genvar k = 0; k < DATA_W; k++) begin : g_hit
    localparam int           POS_I = pos_of(k);
    localparam logic [P-1:0] POS_K = POS_I[P-1:0];
    assign w_hit[k] = (r_s1_syn == POS_K);
  end

  // Odd parity with an in-range syndrome is a single error: s==0 is chk[P],
  // a power of two is a Hamming check bit, anything else is a data bit.
  assign w_ce    = r_s1_pe && (r_s1_syn <= NPOS_L);
  // Odd parity pointing outside the codeword, or even parity with a nonzero
  // syndrome (two flips), cannot be corrected.
  assign w_ue    = (r_s1_pe && (r_s1_syn > NPOS_L)) ||
                   (!r_s1_pe && (r_s1_syn != '0));
  // Check-bit and out-of-range syndromes never hit a data position, so only
  // genuine single data errors are flipped.
  assign w_flip  = w_hit & {DATA_W{r_s1_pe && r_s1_cen}};
  assign w_cdata = r_s1_data ^ w_flip;

  logic [DATA_W-1:0] r_s2_data;
  logic [P-1:0]      r_s2_syn;
  logic              r_s2_ce;
  logic              r_s2_ue;

  // Loads only with a valid beat so outputs hold while stalled or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_data <= '0;
      r_s2_syn  <= '0;
      r_s2_ce   <= 1'b0;
      r_s2_ue   <= 1'b0;
    end else if (w_s2_en && r_vld_pipe[1]) begin
      r_s2_data <= w_cdata;
      r_s2_syn  <= r_s1_syn;
      r_s2_ce   <= w_ce;
      r_s2_ue   <= w_ue;
    end
  end

  assign out_valid    = r_vld_pipe[2];
  assign out_data     = r_s2_data;
  assign out_syndrome = r_s2_syn;
  assign out_ce       = r_s2_ce;
  assign out_ue       = r_s2_ue;

  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  logic w_out_hs;
  logic [CNT_W-1:0] r_ce_cnt;
  logic [CNT_W-1:0] r_ue_cnt;

  assign w_out_hs = r_vld_pipe[2] && out_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_s2_ce && !(&r_ce_cnt)) r_ce_cnt <= r_ce_cnt + 1'b1;
      if (r_s2_ue && !(&r_ue_cnt)) r_ue_cnt <= r_ue_cnt + 1'b1;
    end
  end

  assign ce_cnt = r_ce_cnt;
  assign ue_cnt = r_ue_cnt;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
module tb_ecc_secded_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- DUT A: DATA_W=32, CNT_W=16 ----------------
  logic        a_rst, a_in_valid, a_in_ready, a_cen, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [6:0]  a_in_chk;
  logic        a_out_ce, a_out_ue, a_cnt_clr;
  logic [5:0]  a_out_syn;
  logic [15:0] a_ce_cnt, a_ue_cnt;

  ecc_secded_pipe #(.DATA_W(32), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_chk(a_in_chk), .correct_en(a_cen),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ce(a_out_ce), .out_ue(a_out_ue), .out_syndrome(a_out_syn),
    .ce_cnt(a_ce_cnt), .ue_cnt(a_ue_cnt), .cnt_clr(a_cnt_clr));

  // ---------------- DUT B: DATA_W=32, CNT_W=2 ----------------
  logic        b_rst, b_in_valid, b_in_ready, b_cen, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [6:0]  b_in_chk;
  logic        b_out_ce, b_out_ue, b_cnt_clr;
  logic [5:0]  b_out_syn;
  logic [1:0]  b_ce_cnt, b_ue_cnt;

  ecc_secded_pipe #(.DATA_W(32), .CNT_W(2)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_chk(b_in_chk), .correct_en(b_cen),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ce(b_out_ce), .out_ue(b_out_ue), .out_syndrome(b_out_syn),
    .ce_cnt(b_ce_cnt), .ue_cnt(b_ue_cnt), .cnt_clr(b_cnt_clr));

  typedef struct {
    logic [31:0] data;
    logic [6:0]  chk;
    logic        cen;
    logic [31:0] edata;
    logic        ece;
    logic        eue;
    logic [5:0]  esyn;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  int exp_ce, exp_ue;

  initial begin
    // data positions: d0=3, d1=5, d31=38
    vt[0]  = '{32'h0000_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 6'd0};  // clean zero
    vt[1]  = '{32'h0000_0001, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd3};  // d0 flipped
    vt[2]  = '{32'h0000_0001, 7'h00, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 6'd3};  // same, raw
    vt[3]  = '{32'h0000_0000, 7'h40, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd0};  // chk[P]
    vt[4]  = '{32'h0000_0000, 7'h04, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd4};  // chk[2]
    vt[5]  = '{32'h0000_0003, 7'h00, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 6'd6};  // double
    vt[6]  = '{32'h0000_0003, 7'h00, 1'b0, 32'h0000_0003, 1'b0, 1'b1, 6'd6};  // double raw
    vt[7]  = '{32'h8000_0000, 7'h26, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 6'd0};  // clean d31
    vt[8]  = '{32'h8000_0000, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd38}; // top position
    vt[9]  = '{32'h0000_0000, 7'h7F, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 6'd63}; // s>NPOS, pe=1
    vt[10] = '{32'h0000_0000, 7'h67, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 6'd39}; // s=NPOS+1
    vt[11] = '{32'h0000_0000, 7'h43, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 6'd3};  // correct to 1
    vt[12] = '{32'h0000_0001, 7'h43, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 6'd0};  // clean d0
    vt[13] = '{32'h0000_0002, 7'h00, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd5};  // d1
    vt[14] = '{32'h0000_0000, 7'h3F, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 6'd63}; // pe=0, s!=0
    vt[15] = '{32'h0000_0000, 7'h20, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 6'd32}; // chk[5]
    vt[16] = '{32'h0000_0001, 7'h40, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 6'd3};  // data+chk[P]

    a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_chk = '0; a_cen = 1'b1;
    a_out_ready = 1'b1; a_cnt_clr = 1'b0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_chk = '0; b_cen = 1'b1;
    b_out_ready = 1'b1; b_cnt_clr = 1'b0;
    exp_ce = 0; exp_ue = 0;

    repeat (2) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    check("rst out_valid", a_out_valid, 0);
    check("rst out_data",  a_out_data, 0);
    check("rst out_ce",    a_out_ce, 0);
    check("rst out_ue",    a_out_ue, 0);
    check("rst syndrome",  a_out_syn, 0);
    check("rst ce_cnt",    a_ce_cnt, 0);
    check("rst ue_cnt",    a_ue_cnt, 0);
    check("rst in_ready",  a_in_ready, 1);

    // ---------------- table-driven single beats ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = vt[i].data; a_in_chk = vt[i].chk; a_cen = vt[i].cen;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_data = 32'hDEAD_BEEF; a_in_chk = 7'h55;
      check($sformatf("v%0d early valid", i), a_out_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), a_out_valid, 1);
      check($sformatf("v%0d data", i), a_out_data, vt[i].edata);
      check($sformatf("v%0d ce", i),   a_out_ce, vt[i].ece);
      check($sformatf("v%0d ue", i),   a_out_ue, vt[i].eue);
      check($sformatf("v%0d syn", i),  a_out_syn, vt[i].esyn);
      exp_ce += int'(vt[i].ece);
      exp_ue += int'(vt[i].eue);
      @(negedge clk);
      check($sformatf("v%0d drained", i), a_out_valid, 0);
      check($sformatf("v%0d ce_cnt", i), a_ce_cnt, exp_ce);
      check($sformatf("v%0d ue_cnt", i), a_ue_cnt, exp_ue);
    end

    // ---------------- clear then backpressure ----------------
    a_cnt_clr = 1'b1;
    @(negedge clk);
    a_cnt_clr = 1'b0;
    check("clr ce_cnt", a_ce_cnt, 0);
    check("clr ue_cnt", a_ue_cnt, 0);

    begin
      int bi [4];
      int ii, oi, acc_lo;
      logic acc;
      bi[0] = 7; bi[1] = 1; bi[2] = 5; bi[3] = 12;
      ii = 0; oi = 0; acc_lo = 0; acc = 1'b0;
      for (int c = 0; c < 40 && oi < 4; c++) begin
        @(negedge clk);
        a_out_ready = (c >= 5);
        if (acc) ii++;
        if (ii < 4) begin
          a_in_valid = 1'b1; a_in_data = vt[bi[ii]].data;
          a_in_chk = vt[bi[ii]].chk; a_cen = vt[bi[ii]].cen;
        end else begin
          a_in_valid = 1'b0;
        end
        #1;
        acc = a_in_valid && a_in_ready;
        if (c < 5 && acc) acc_lo++;
        if (c == 2) check("bp in_ready low", a_in_ready, 0);
        if (c == 5) check("bp in_ready comb", a_in_ready, 1);
        if (a_out_valid) begin
          if (a_out_ready) begin
            check($sformatf("bp beat%0d data", oi), a_out_data, vt[bi[oi]].edata);
            check($sformatf("bp beat%0d ce", oi),   a_out_ce,   vt[bi[oi]].ece);
            check($sformatf("bp beat%0d ue", oi),   a_out_ue,   vt[bi[oi]].eue);
            check($sformatf("bp beat%0d syn", oi),  a_out_syn,  vt[bi[oi]].esyn);
            oi++;
          end else begin
            check($sformatf("bp hold c%0d", c), a_out_data, vt[bi[oi]].edata);
          end
        end
      end
      check("bp all beats out", oi, 4);
      check("bp accepted while stalled", acc_lo, 2);
      @(negedge clk);
      a_in_valid = 1'b0;
      check("bp no extra beat", a_out_valid, 0);
      check("bp ce_cnt", a_ce_cnt, 1);
      check("bp ue_cnt", a_ue_cnt, 1);
    end

    // ---------------- saturation on the 2-bit counter DUT ----------------
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 32'h0000_0001; b_in_chk = 7'h00; b_cen = 1'b1;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat ce_cnt", b_ce_cnt, 3);
    check("sat ue_cnt", b_ue_cnt, 0);

    // cnt_clr together with a ce handshake
    b_in_valid = 1'b1; b_in_data = 32'h0000_0001; b_in_chk = 7'h00;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    check("clr-hs out_ce", b_out_ce, 1);
    check("clr-hs out_valid", b_out_valid, 1);
    b_cnt_clr = 1'b1;
    @(negedge clk);
    b_cnt_clr = 1'b0;
    check("clr-hs ce_cnt", b_ce_cnt, 0);

    // reset with two beats in flight
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'h0000_0001; b_in_chk = 7'h00;
    @(negedge clk);
    b_in_data = 32'h0000_0003;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("inflight out_valid", b_out_valid, 1);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    b_out_ready = 1'b1;
    check("midrst out_valid", b_out_valid, 0);
    check("midrst in_ready", b_in_ready, 1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("midrst gone c%0d", n), b_out_valid, 0);
    end
    check("midrst ce_cnt", b_ce_cnt, 0);
    check("midrst ue_cnt", b_ue_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
